lfa_seg_accumulator: RTL and testbench



---
 rtl/lfa_acc_pkg.sv | 16 +
 rtl/lfa_prefix_add16.sv | 60 ++++++
 rtl/lfa_seg_accumulator.sv | 135 +++++++++++++
 tb/tb_lfa_seg_accumulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfa_acc_pkg.sv
// Shared constants, FSM state type and sizing helper for the segmented accumulator.
package lfa_acc_pkg;

  localparam int SEG_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nseg(input int acc_w);
    calc_nseg = acc_w / SEG_W;
  endfunction

endpackage

// File: rtl/lfa_prefix_add16.sv
// Combinational 16-bit Ladner-Fischer prefix adder with carry-in; s[16] is the carry-out.
module lfa_prefix_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] s
);

  logic [15:0] g0_s, p0_s, g1_s, p1_s, g2_s, p2_s, g3_s, p3_s, g4_s, p4_s;

  // Carry-in is folded into bit 0 so the tree yields carries that already include it.
  assign p0_s = a ^ b;
  assign g0_s = {a[15:1] & b[15:1], (a[0] & b[0]) | (p0_s[0] & cin)};

  for (genvar i = 0; i < 16; i++) begin : g_bit
    localparam int J0 = ((i / 1) * 1) - 1;
    localparam int J1 = ((i / 2) * 2) - 1;
    localparam int J2 = ((i / 4) * 4) - 1;
    localparam int J3 = ((i / 8) * 8) - 1;

    if ((i / 1) % 2 == 1) begin : g_l0
      assign g1_s[i] = g0_s[i] | (p0_s[i] & g0_s[J0]);
      assign p1_s[i] = p0_s[i] & p0_s[J0];
    end else begin : g_l0_pass
      assign g1_s[i] = g0_s[i];
      assign p1_s[i] = p0_s[i];
    end

    if ((i / 2) % 2 == 1) begin : g_l1
      assign g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[J1]);
      assign p2_s[i] = p1_s[i] & p1_s[J1];
    end else begin : g_l1_pass
      assign g2_s[i] = g1_s[i];
      assign p2_s[i] = p1_s[i];
    end

    if ((i / 4) % 2 == 1) begin : g_l2
      assign g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[J2]);
      assign p3_s[i] = p2_s[i] & p2_s[J2];
    end else begin : g_l2_pass
      assign g3_s[i] = g2_s[i];
      assign p3_s[i] = p2_s[i];
    end

    if ((i / 8) % 2 == 1) begin : g_l3
      assign g4_s[i] = g3_s[i] | (p3_s[i] & g3_s[J3]);
      assign p4_s[i] = p3_s[i] & p3_s[J3];
    end else begin : g_l3_pass
      assign g4_s[i] = g3_s[i];
      assign p4_s[i] = p3_s[i];
    end
  end

  // Group propagate of the full tree is only needed internally; the sum uses generates.
  logic unused_p_s;
  assign unused_p_s = ^p4_s;

  assign s = {g4_s[15], p0_s ^ {g4_s[14:0], cin}};

endmodule

// File: rtl/lfa_seg_accumulator.sv
// Streaming frame accumulator that time-shares one 16-bit prefix adder across ACC_W/16 segments.
// Optional feature macro: LFA_ACC_SIGNED_EN (two's-complement operands and signed overflow).
module lfa_seg_accumulator
  import lfa_acc_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int NSEG  = calc_nseg(ACC_W);
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_e                       state_r;
  logic [CNT_W-1:0]             seg_r;
  logic [NSEG-1:0][SEG_W-1:0]   acc_r;
  logic [SEG_W-1:0]             opnd_r;
  logic                         last_r;
  logic                         carry_r;
  logic                         ovf_r;
  logic                         in_ready_r;
  logic                         out_valid_r;

  logic [SEG_W-1:0]             x_s;
  logic [SEG_W-1:0]             y_s;
  logic [SEG_W-1:0]             ext_s;
  logic [SEG_W:0]               sum_s;
  logic                         top_s;
  logic                         ovf_bit_s;

  // Select the accumulator segment addressed by the segment counter.
  always_comb begin
    x_s = {SEG_W{1'b0}};
    for (int k = 0; k < NSEG; k++) begin
      x_s = x_s | (acc_r[k] & {SEG_W{seg_r == CNT_W'(k)}});
    end
  end

`ifdef LFA_ACC_SIGNED_EN
  assign ext_s     = {SEG_W{opnd_r[SEG_W-1]}};
  assign ovf_bit_s = (x_s[SEG_W-1] == y_s[SEG_W-1]) && (sum_s[SEG_W-1] != x_s[SEG_W-1]);
`else
  assign ext_s     = {SEG_W{1'b0}};
  assign ovf_bit_s = sum_s[SEG_W];
`endif

  assign y_s   = (seg_r == {CNT_W{1'b0}}) ? opnd_r : ext_s;
  assign top_s = (seg_r == CNT_W'(NSEG - 1));

  lfa_prefix_add16 u_add (
    .a   (x_s),
    .b   (y_s),
    .cin (carry_r),
    .s   (sum_s)
  );

  // Frame FSM: accept an operand, add it one segment per cycle, then hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      seg_r       <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      opnd_r      <= {SEG_W{1'b0}};
      last_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            opnd_r     <= in_data;
            last_r     <= in_last;
            seg_r      <= {CNT_W{1'b0}};
            carry_r    <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= ADD;
          end
        end
        ADD: begin
          for (int k = 0; k < NSEG; k++) begin
            if (seg_r == CNT_W'(k)) begin
              acc_r[k] <= sum_s[SEG_W-1:0];
            end
          end
          carry_r <= sum_s[SEG_W];
          if (top_s) begin
            ovf_r <= ovf_r | ovf_bit_s;
            if (last_r) begin
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= IDLE;
            end
          end else begin
            seg_r <= seg_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_r       <= {ACC_W{1'b0}};
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Gated with rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = in_ready_r & rst_n;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_lfa_seg_accumulator.sv
// Self-checking bench: a 32-bit and a 16-bit accumulator checked against an arithmetic frame model.
module tb_lfa_seg_accumulator;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_ovf_a, out_ovf_b;
  logic [31:0] out_sum_a;
  logic [15:0] out_sum_b;

  logic        in_ready_o, out_valid_o, out_ovf_o;
  logic [31:0] out_sum_o;

  int     ncmp;
  int     nfail;
  longint macc;
  bit     movf;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready & sel;
  assign in_ready_o  = sel ? in_ready_b : in_ready_a;
  assign out_valid_o = sel ? out_valid_b : out_valid_a;
  assign out_ovf_o   = sel ? out_ovf_b : out_ovf_a;
  assign out_sum_o   = sel ? {16'h0000, out_sum_b} : out_sum_a;

  lfa_seg_accumulator #(.ACC_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_sum(out_sum_a), .out_ovf(out_ovf_a)
  );

  lfa_seg_accumulator #(.ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_sum(out_sum_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_now();
    return sel ? 16 : 32;
  endfunction

  function automatic logic [31:0] exp_sum();
    return 32'(macc & ((longint'(1) << width_now()) - longint'(1)));
  endfunction

  // Exact-integer frame model: add, detect out-of-range, wrap modulo 2^w.
  task automatic model_add(input logic [15:0] d);
    longint v, s, lim;
`ifdef LFA_ACC_SIGNED_EN
    v   = longint'($signed(d));
    lim = longint'(1) << (width_now() - 1);
    s   = macc + v;
    if (s >= lim) begin
      movf = 1'b1;
      s    = s - (lim << 1);
    end else if (s < -lim) begin
      movf = 1'b1;
      s    = s + (lim << 1);
    end
`else
    v   = longint'({48'h0, d});
    lim = longint'(1) << width_now();
    s   = macc + v;
    if (s >= lim) begin
      movf = 1'b1;
      s    = s - lim;
    end
`endif
    macc = s;
  endtask

  task automatic do_word(input logic [15:0] d, input logic last, input logic hold);
    int cnt;
    int nseg;
    nseg     = sel ? 1 : 2;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    cnt      = 0;
    while (!in_ready_o && cnt < 50) begin
      tick();
      cnt++;
    end
    check("ready_wait", {31'h0, in_ready_o}, 32'h1);
    if (hold) check("b2b_gap", cnt, 32'h0);
    tick();
    if (!hold) in_valid = 1'b0;
    model_add(d);
    for (int i = 0; i < nseg; i++) begin
      check("add_in_ready", {31'h0, in_ready_o}, 32'h0);
      check("add_out_valid", {31'h0, out_valid_o}, 32'h0);
      tick();
    end
    check("post_in_ready", {31'h0, in_ready_o}, {31'h0, ~last});
    check("post_out_valid", {31'h0, out_valid_o}, {31'h0, last});
    check("post_sum", out_sum_o, exp_sum());
    check("post_ovf", {31'h0, out_ovf_o}, {31'h0, movf});
  endtask

  task automatic finish_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      check("bp_out_valid", {31'h0, out_valid_o}, 32'h1);
      check("bp_in_ready", {31'h0, in_ready_o}, 32'h0);
      check("bp_sum", out_sum_o, exp_sum());
      check("bp_ovf", {31'h0, out_ovf_o}, {31'h0, movf});
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    macc      = 0;
    movf      = 1'b0;
    check("hs_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("hs_in_ready", {31'h0, in_ready_o}, 32'h1);
    check("hs_sum_clr", out_sum_o, 32'h0);
    check("hs_ovf_clr", {31'h0, out_ovf_o}, 32'h0);
  endtask

  initial begin
    logic [15:0] d;
    int          n;
    ncmp      = 0;
    nfail     = 0;
    macc      = 0;
    movf      = 1'b0;
    sel       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state of both instances.
    repeat (3) tick();
    check("rst_in_ready_a", {31'h0, in_ready_a}, 32'h0);
    check("rst_in_ready_b", {31'h0, in_ready_b}, 32'h0);
    check("rst_out_valid_a", {31'h0, out_valid_a}, 32'h0);
    check("rst_out_valid_b", {31'h0, out_valid_b}, 32'h0);
    check("rst_sum_a", out_sum_a, 32'h0);
    check("rst_sum_b", {16'h0, out_sum_b}, 32'h0);
    check("rst_ovf_a", {31'h0, out_ovf_a}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_a", {31'h0, in_ready_a}, 32'h1);
    check("rel_in_ready_b", {31'h0, in_ready_b}, 32'h1);

    // Directed frames from the test plan.
`ifdef LFA_ACC_SIGNED_EN
    sel = 1'b0;
    do_word(16'hFFFF, 1'b0, 1'b0);
    do_word(16'h0003, 1'b1, 1'b0);
    check("s32_sum", out_sum_o, 32'h0000_0002);
    check("s32_ovf", {31'h0, out_ovf_o}, 32'h0);
    finish_frame(0);
    sel = 1'b1;
    do_word(16'h7FFF, 1'b0, 1'b0);
    do_word(16'h0001, 1'b1, 1'b0);
    check("s16_sum", out_sum_o, 32'h0000_8000);
    check("s16_ovf", {31'h0, out_ovf_o}, 32'h1);
    finish_frame(0);
`else
    sel = 1'b0;
    do_word(16'hFFFF, 1'b0, 1'b0);
    do_word(16'h0001, 1'b1, 1'b0);
    check("u32_sum", out_sum_o, 32'h0001_0000);
    check("u32_ovf", {31'h0, out_ovf_o}, 32'h0);
    finish_frame(0);
    sel = 1'b1;
    do_word(16'hFFFF, 1'b0, 1'b0);
    do_word(16'h0002, 1'b1, 1'b0);
    check("u16_sum", out_sum_o, 32'h0000_0001);
    check("u16_ovf", {31'h0, out_ovf_o}, 32'h1);
    finish_frame(0);
`endif
    do_word(16'h0005, 1'b1, 1'b0);
    check("sticky_clr_sum", out_sum_o, 32'h0000_0005);
    check("sticky_clr_ovf", {31'h0, out_ovf_o}, 32'h0);
    finish_frame(0);

    // Back-to-back stream with in_valid held, then backpressure in DONE.
    sel = 1'b0;
    for (int i = 0; i < 4; i++) do_word(16'h4000, (i == 3), 1'b1);
    check("b2b_sum", out_sum_o, 32'h0001_0000);
    check("b2b_ovf", {31'h0, out_ovf_o}, 32'h0);
    finish_frame(5);
    tick();
    check("bp_no_accept", {31'h0, in_ready_o}, 32'h1);

    // Reset during ADD segment 1.
    in_data  = 16'h5555;
    in_last  = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_in_ready", {31'h0, in_ready_o}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, in_ready_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    macc = 0;
    movf = 1'b0;
    check("mid_idle_ready", {31'h0, in_ready_o}, 32'h1);
    check("mid_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("mid_sum_clr", out_sum_o, 32'h0);
    do_word(16'h1234, 1'b1, 1'b0);
    check("mid_frame_sum", out_sum_o, 32'h0000_1234);
    finish_frame(1);

    // Randomized frames on both widths.
    for (int f = 0; f < 40; f++) begin
      sel = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 4));
      for (int w = 0; w < n; w++) begin
        case ($urandom_range(0, 3))
          0:       d = 16'hFFFF - 16'($urandom_range(0, 3));
          1:       d = 16'h7FFF + 16'($urandom_range(0, 2));
          default: d = 16'($urandom);
        endcase
        do_word(d, (w == n - 1), 1'b0);
      end
      finish_frame(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
